// File: rtl/vote_pkg.sv
// Shared types and constants for the ballot intake path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vote_pkg;

   localparam int N_CAND   = 3;
   localparam int N_VOTERS = 5;
   localparam int CNT_W    = 3;

   typedef logic [N_CAND-1:0] ballot_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ONE_HOT   = 2'd0,
      ABSTAIN   = 2'd1,
      MALFORMED = 2'd2
   } ballot_class_t;

endpackage

// File: rtl/ballot_collector_if.sv
// Ballot offer handshake between a ballot source and the collector.
// Latency: n/a (wires only).
// Backpressure: source holds vote_data while vote_valid is high and vote_ready is low.
interface ballot_collector_if;
   import vote_pkg::*;

   logic    vote_valid;
   ballot_t vote_data;
   logic    vote_ready;
   logic    vote_reject;

   modport master (
      output vote_valid,
      output vote_data,
      input  vote_ready,
      input  vote_reject
   );

   modport slave (
      input  vote_valid,
      input  vote_data,
      output vote_ready,
      output vote_reject
   );

endinterface

// File: rtl/ballot_check.sv
// Classifies one ballot and produces the per-candidate tally increment.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of vote_data.
module ballot_check
   import vote_pkg::*;
(
   input  ballot_t              vote_data,
   output ballot_class_t        ballot_class,
   output logic [N_CAND-1:0]    tally_inc
);

   // Only a single set bit counts as a vote; zero bits is an abstention.
   always_comb begin
      ballot_class = MALFORMED;
      tally_inc    = '0;
      case (vote_data)
         3'b000: begin
            ballot_class = ABSTAIN;
         end
         3'b001, 3'b010, 3'b100: begin
            ballot_class = ONE_HOT;
            tally_inc    = vote_data;
         end
         default: begin
            ballot_class = MALFORMED;
         end
      endcase
   end

endmodule

// File: rtl/ballot_collector.sv
// Collects five validated ballots, keeps per-candidate tallies, presents the set.
// Latency: ballot accepted at edge t is visible (slot/count/tally) at t+1.
// Backpressure: vote_ready is registered from state only; low in IDLE and FULL.
module ballot_collector
   import vote_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   ballot_collector_if.slave    vote,
   output ballot_t              ballot_a,
   output ballot_t              ballot_b,
   output ballot_t              ballot_c,
   output ballot_t              ballot_d,
   output ballot_t              ballot_e,
   output logic                 ballots_valid,
   output cnt_t                 count,
   output cnt_t                 tally0,
   output cnt_t                 tally1,
   output cnt_t                 tally2
);

   state_t              state;
   ballot_t             slot [N_VOTERS];
   cnt_t                tally [N_CAND];
   cnt_t                count_q;
   logic                ready_q;
   logic                reject_q;
   logic                valid_q;

   ballot_class_t       ballot_class;
   logic [N_CAND-1:0]   tally_inc;
   logic                accept;

   ballot_check u_check (
      .vote_data    (vote.vote_data),
      .ballot_class (ballot_class),
      .tally_inc    (tally_inc)
   );

   // ready_q is only ever high in COLLECT, so it alone qualifies acceptance.
   assign accept = vote.vote_valid & ready_q;

   // State machine plus all stored data; start overrides any ballot in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready_q  <= 1'b0;
         reject_q <= 1'b0;
         valid_q  <= 1'b0;
         count_q  <= '0;
         for (int i = 0; i < N_VOTERS; i++) slot[i]  <= '0;
         for (int k = 0; k < N_CAND; k++)   tally[k] <= '0;
      end else if (start) begin
         state    <= COLLECT;
         ready_q  <= 1'b1;
         reject_q <= 1'b0;
         valid_q  <= 1'b0;
         count_q  <= '0;
         for (int i = 0; i < N_VOTERS; i++) slot[i]  <= '0;
         for (int k = 0; k < N_CAND; k++)   tally[k] <= '0;
      end else begin
         reject_q <= 1'b0;
         case (state)
            COLLECT: begin
               if (accept) begin
                  if (ballot_class == MALFORMED) begin
                     reject_q <= 1'b1;
                  end else begin
                     for (int i = 0; i < N_VOTERS; i++) begin
                        if (count_q == CNT_W'(i)) slot[i] <= vote.vote_data;
                     end
                     for (int k = 0; k < N_CAND; k++) begin
                        tally[k] <= tally[k] + {{(CNT_W-1){1'b0}}, tally_inc[k]};
                     end
                     count_q <= count_q + 1'b1;
                     if (count_q == CNT_W'(N_VOTERS - 1)) begin
                        state   <= FULL;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                     end
                  end
               end
            end
            FULL: begin
               ready_q <= 1'b0;
               valid_q <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign vote.vote_ready  = ready_q;
   assign vote.vote_reject = reject_q;

   assign ballot_a      = slot[0];
   assign ballot_b      = slot[1];
   assign ballot_c      = slot[2];
   assign ballot_d      = slot[3];
   assign ballot_e      = slot[4];
   assign ballots_valid = valid_q;
   assign count         = count_q;
   assign tally0        = tally[0];
   assign tally1        = tally[1];
   assign tally2        = tally[2];

endmodule

// File: tb/tb_ballot_collector.sv
// Directed bench for ballot_collector with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stimulus only offers ballots; readiness is checked explicitly.
module tb_ballot_collector;
   import vote_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n;
   logic    start;
   ballot_t ballot_a, ballot_b, ballot_c, ballot_d, ballot_e;
   logic    ballots_valid;
   cnt_t    count, tally0, tally1, tally2;

   int checks = 0;
   int errors = 0;

   ballot_collector_if bif ();

   ballot_collector dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .vote          (bif.slave),
      .ballot_a      (ballot_a),
      .ballot_b      (ballot_b),
      .ballot_c      (ballot_c),
      .ballot_d      (ballot_d),
      .ballot_e      (ballot_e),
      .ballots_valid (ballots_valid),
      .count         (count),
      .tally0        (tally0),
      .tally1        (tally1),
      .tally2        (tally2)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Begin a new election: one start cycle, then idle inputs.
   task automatic do_start;
      start = 1'b1;
      bif.vote_valid = 1'b0;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input ballot_t b);
      bif.vote_valid = 1'b1;
      bif.vote_data  = b;
      tick();
      bif.vote_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; bif.vote_valid = 1'b0; bif.vote_data = '0;
      tick(); tick();
      checks++; if (bif.vote_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bif.vote_ready); end
      checks++; if (bif.vote_reject !== 1'b0) begin errors++; $display("FAIL reset_reject got %b want 0", bif.vote_reject); end
      checks++; if (ballots_valid !== 1'b0) begin errors++; $display("FAIL reset_bvalid got %b want 0", ballots_valid); end
      checks++; if ({count, tally0, tally1, tally2} !== 12'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d/%0d/%0d want 0/0/0/0", count, tally0, tally1, tally2); end
      checks++; if ({ballot_a, ballot_b, ballot_c, ballot_d, ballot_e} !== 15'd0) begin errors++; $display("FAIL reset_slots got %b want all zero", {ballot_a, ballot_b, ballot_c, ballot_d, ballot_e}); end
      rst_n = 1'b1;
      // vote_valid while IDLE must not be taken.
      bif.vote_valid = 1'b1; bif.vote_data = 3'b001;
      tick(); tick();
      bif.vote_valid = 1'b0;
      checks++; if (count !== 3'd0 || bif.vote_ready !== 1'b0) begin errors++; $display("FAIL idle_ignore count=%0d ready=%b want 0/0", count, bif.vote_ready); end
   endtask

   task automatic test_full_election;
      ballot_t seq [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b010};
      do_start();
      checks++; if (bif.vote_ready !== 1'b1) begin errors++; $display("FAIL start_ready got %b want 1", bif.vote_ready); end
      // Ballots back to back: valid held for five consecutive edges.
      bif.vote_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bif.vote_data = seq[i];
         tick();
         checks++; if (count !== cnt_t'(i + 1)) begin errors++; $display("FAIL full_count_step%0d got %0d want %0d", i, count, i + 1); end
      end
      bif.vote_valid = 1'b0;
      checks++; if (ballots_valid !== 1'b1) begin errors++; $display("FAIL full_bvalid got %b want 1", ballots_valid); end
      checks++; if (bif.vote_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bif.vote_ready); end
      checks++; if (tally0 !== 3'd1 || tally1 !== 3'd2 || tally2 !== 3'd2) begin errors++; $display("FAIL full_tally got %0d/%0d/%0d want 1/2/2", tally0, tally1, tally2); end
      checks++; if ({ballot_a, ballot_b, ballot_c, ballot_d, ballot_e} !== {3'b001, 3'b010, 3'b100, 3'b100, 3'b010}) begin errors++; $display("FAIL full_slots got %b want 001010100100010", {ballot_a, ballot_b, ballot_c, ballot_d, ballot_e}); end
   endtask

   task automatic test_malformed;
      do_start();
      send(3'b011);
      checks++; if (bif.vote_reject !== 1'b1) begin errors++; $display("FAIL rej1_pulse got %b want 1", bif.vote_reject); end
      tick();
      checks++; if (bif.vote_reject !== 1'b0) begin errors++; $display("FAIL rej1_clear got %b want 0", bif.vote_reject); end
      send(3'b110);
      checks++; if (bif.vote_reject !== 1'b1) begin errors++; $display("FAIL rej2_pulse got %b want 1", bif.vote_reject); end
      tick();
      checks++; if (bif.vote_reject !== 1'b0) begin errors++; $display("FAIL rej2_clear got %b want 0", bif.vote_reject); end
      send(3'b111);
      checks++; if (bif.vote_reject !== 1'b1) begin errors++; $display("FAIL rej3_pulse got %b want 1", bif.vote_reject); end
      checks++; if (count !== 3'd0 || {tally0, tally1, tally2} !== 9'd0) begin errors++; $display("FAIL rej_counts got %0d/%0d/%0d/%0d want 0", count, tally0, tally1, tally2); end
      checks++; if ({ballot_a, ballot_b, ballot_c, ballot_d, ballot_e} !== 15'd0) begin errors++; $display("FAIL rej_slots got %b want all zero", {ballot_a, ballot_b, ballot_c, ballot_d, ballot_e}); end
      checks++; if (bif.vote_ready !== 1'b1) begin errors++; $display("FAIL rej_ready got %b want 1", bif.vote_ready); end
   endtask

   task automatic test_abstain;
      do_start();
      send(3'b000); send(3'b000); send(3'b001); send(3'b000); send(3'b000);
      checks++; if (count !== 3'd5) begin errors++; $display("FAIL abst_count got %0d want 5", count); end
      checks++; if (tally0 !== 3'd1 || tally1 !== 3'd0 || tally2 !== 3'd0) begin errors++; $display("FAIL abst_tally got %0d/%0d/%0d want 1/0/0", tally0, tally1, tally2); end
      checks++; if (ballots_valid !== 1'b1) begin errors++; $display("FAIL abst_bvalid got %b want 1", ballots_valid); end
      checks++; if (ballot_c !== 3'b001 || ballot_e !== 3'b000) begin errors++; $display("FAIL abst_slots got c=%b e=%b want 001/000", ballot_c, ballot_e); end
   endtask

   // Entered from FULL left by test_abstain.
   task automatic test_full_hold;
      bif.vote_valid = 1'b1; bif.vote_data = 3'b001;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (count !== 3'd5 || tally0 !== 3'd1 || ballots_valid !== 1'b1 || bif.vote_ready !== 1'b0 || ballot_a !== 3'b000 || ballot_c !== 3'b001) begin
            errors++; $display("FAIL hold_cyc%0d got cnt=%0d t0=%0d bv=%b rdy=%b a=%b c=%b want 5/1/1/0/000/001", i, count, tally0, ballots_valid, bif.vote_ready, ballot_a, ballot_c);
         end
      end
      bif.vote_valid = 1'b0;
   endtask

   task automatic test_restart;
      do_start();
      send(3'b001); send(3'b010); send(3'b100);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL rst_pre_count got %0d want 3", count); end
      start = 1'b1; bif.vote_valid = 1'b1; bif.vote_data = 3'b100;
      tick();
      start = 1'b0; bif.vote_valid = 1'b0;
      checks++; if (count !== 3'd0 || {tally0, tally1, tally2} !== 9'd0) begin errors++; $display("FAIL restart_clear got %0d/%0d/%0d/%0d want 0", count, tally0, tally1, tally2); end
      checks++; if (bif.vote_reject !== 1'b0 || bif.vote_ready !== 1'b1) begin errors++; $display("FAIL restart_hs rej=%b rdy=%b want 0/1", bif.vote_reject, bif.vote_ready); end
      checks++; if (ballot_a !== 3'b000) begin errors++; $display("FAIL restart_slot got %b want 000", ballot_a); end
      send(3'b010);
      checks++; if (count !== 3'd1 || ballot_a !== 3'b010 || tally1 !== 3'd1) begin errors++; $display("FAIL restart_next got cnt=%0d a=%b t1=%0d want 1/010/1", count, ballot_a, tally1); end
   endtask

   task automatic test_reset_mid;
      do_start();
      send(3'b100); send(3'b001);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if ({count, tally0, tally1, tally2} !== 12'd0 || ballots_valid !== 1'b0 || bif.vote_reject !== 1'b0) begin errors++; $display("FAIL midrst_regs got %0d/%0d/%0d/%0d bv=%b want zeros", count, tally0, tally1, tally2, ballots_valid); end
      checks++; if ({ballot_a, ballot_b} !== 6'd0) begin errors++; $display("FAIL midrst_slots got %b want 000000", {ballot_a, ballot_b}); end
      bif.vote_valid = 1'b1; bif.vote_data = 3'b010;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bif.vote_ready !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL midrst_idle%0d rdy=%b cnt=%0d want 0/0", i, bif.vote_ready, count); end
         tick();
      end
      bif.vote_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_election();
      test_malformed();
      test_abstain();
      test_full_hold();
      test_restart();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
